ysyx_24100006_imem_resp: RTL and testbench
==========================================

// Module: ysyx_24100006_imem_resp
// PURPOSE
//  AXI4-Lite read-only responder serving instruction fetches issued from the PC/IF stage.
//  Accepts a fetch address on AR, waits a programmable latency, returns the word on R.
//  Reports misaligned and out-of-range fetches via RRESP; the IF stage maps these onto Access_Fault.
//  Word storage is an internal array, filled through a backdoor init port before fetching starts.
// PARAMETERS
//  BASE_ADDR    32'h8000_0000  byte address of word 0
//  DEPTH_WORDS  4096           number of 32-bit words; power of two, >=2
//  LAT          2              wait cycles between AR handshake and RVALID assertion (0..15)
// PORTS
//  clk          in   1   single clock; all logic rising-edge
//  reset        in   1   asynchronous, active-low reset
//  araddr       in   32  fetch byte address
//  arvalid      in   1   address valid
//  arready      out  1   responder can accept address
//  rdata        out  32  instruction word (0 on error)
//  rresp        out  2   00 OKAY, 10 SLVERR (misaligned), 11 DECERR (out of range)
//  rvalid       out  1   response valid
//  rready       in   1   initiator accepts response
//  init_we      in   1   backdoor word write enable
//  init_idx     in   $clog2(DEPTH_WORDS)  backdoor word index
//  init_data    in   32  backdoor write data
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, arready=0 while asserted then 1 first cycle after release,
//    rvalid=0, rdata=0, rresp=00, wait counter=0. Array contents NOT reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. One outstanding transaction; no AR acceptance outside IDLE.
//  - IDLE: arready=1. arvalid&arready: latch araddr, counter<=LAT; next state WAIT (LAT>0) or RESP (LAT=0).
//  - WAIT: arready=0; counter decrements each cycle; at counter==1 -> RESP next cycle.
//    Total: RVALID rises exactly LAT+1 cycles after the AR handshake edge.
//  - On entering RESP, rdata/rresp are registered from the array at the latched address:
//    addr[1:0]!=0 -> rresp=10, rdata=0 (misalignment checked first);
//    addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS -> rresp=11, rdata=0;
//    else rresp=00, rdata=mem[(addr-BASE_ADDR)>>2]. Range compare in 33-bit arithmetic (no wrap).
//  - RESP: rvalid=1; rdata/rresp held stable until rvalid&rready; then rvalid=0, state IDLE,
//    arready=1 next cycle (no same-cycle back-to-back accept).
//  - init_we writes mem[init_idx] at clock edge in any state; a write to the word being fetched
//    is visible only if it lands on or before the edge that enters RESP.
//  - Reset mid-transaction: outstanding response discarded, rvalid=0 immediately (async).
//  - arvalid deasserted without handshake: no effect. rready while rvalid=0: ignored.
// CONFIGURATION
//  IMEM_RAND_DELAY_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances each
//    AR handshake; its low 2 bits add 0..3 extra WAIT cycles to LAT. Data/resp rules unchanged.
//  Undefined: latency exactly LAT, no LFSR logic present.
// TESTING
//  1) init mem[0]=32'h0000_0413; araddr=32'h8000_0000, rready=1, LAT=2 -> rvalid 3 cycles after AR, rdata=32'h0000_0413, rresp=00.
//  2) araddr=32'h8000_0002 -> rresp=10, rdata=0; araddr=32'h3000_0000 -> rresp=11, rdata=0.
//  3) araddr=BASE+4*DEPTH_WORDS-4 -> OKAY last word; BASE+4*DEPTH_WORDS -> rresp=11.
//  4) rready held 0 for 5 cycles in RESP -> rvalid, rdata, rresp stable; arready=0 throughout; accept on rready=1.
//  5) reset pulled low in WAIT -> rvalid=0, arready=1 one cycle after release; mem[0] value preserved on refetch.
//  6) IMEM_RAND_DELAY_EN: 16 back-to-back fetches -> each latency in [LAT+1, LAT+4], data correct.

Source files
------------

// File: rtl/ysyx_24100006_imem_resp.sv
// AXI4-Lite read-only instruction memory responder: AR handshake, programmable wait, R response.
// Optional macro IMEM_RAND_DELAY_EN adds 0..3 pseudo-random wait cycles per fetch via an 8-bit LFSR.
module ysyx_24100006_imem_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LAT         = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [31:0]                    rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  input  logic                           init_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] init_idx,
  input  logic [31:0]                    init_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One past the last valid byte, held in 33 bits so a top-of-space window cannot wrap.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  function automatic logic [1:0] classify(input logic [31:0] a);
    if (a[1:0] != 2'b00) begin
      return RESP_SLVERR;
    end
    if (({1'b0, a} < {1'b0, BASE_ADDR}) || ({1'b0, a} >= END_ADDR)) begin
      return RESP_DECERR;
    end
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] load_cnt;
  logic             arready_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;
  logic [31:0]      addr_q;

  logic             ar_hs;
  logic             enter_resp;
  logic [31:0]      fetch_addr;
  logic [IDX_W-1:0] fetch_idx;
  logic [31:0]      fetch_word;
  logic [1:0]       fetch_resp;

  assign ar_hs = arvalid && arready_q && (state_q == S_IDLE);

`ifdef IMEM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; advances once per accepted fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 8'hA5;
    end else if (ar_hs) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign load_cnt = CNT_W'(LAT) + CNT_W'(lfsr_q[1:0]);
`else
  assign load_cnt = CNT_W'(LAT);
`endif

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[init_idx] <= init_data;
    end
  end

  // Zero-latency fetches read straight from the bus; otherwise from the latched address.
  always_comb begin
    fetch_addr = (state_q == S_IDLE) ? araddr : addr_q;
    fetch_idx  = word_idx(fetch_addr);
    fetch_resp = classify(fetch_addr);
    fetch_word = mem_q[fetch_idx];
    if (init_we && (init_idx == fetch_idx)) begin
      fetch_word = init_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          cnt_d = load_cnt;
          if (load_cnt == '0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (rready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arready_q <= (state_d == S_IDLE);
      rvalid_q  <= (state_d == S_RESP);
      if (enter_resp) begin
        rresp_q <= fetch_resp;
        rdata_q <= (fetch_resp == RESP_OKAY) ? fetch_word : 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      addr_q <= araddr;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_ysyx_24100006_imem_resp.sv
// Scoreboard bench for ysyx_24100006_imem_resp: driver queues expected responses, monitor checks R.
module tb_ysyx_24100006_imem_resp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;
  localparam int          IDX_W = 12;

  logic             clk;
  logic             reset;
  logic [31:0]      araddr;
  logic             arvalid;
  logic             arready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;
  logic             init_we;
  logic [IDX_W-1:0] init_idx;
  logic [31:0]      init_data;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  int          hs_cyc = 0;
  bit          seen_rv = 0;
  bit          after_pop = 0;

  ysyx_24100006_imem_resp #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .LAT        (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .init_we  (init_we),
    .init_idx (init_idx),
    .init_data(init_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, req);
  endtask

  // Reference: byte address in, (word, resp) out, computed on wide integers.
  task automatic model(input logic [31:0] a, output exp_t e);
    longint ua;
    ua = longint'(a);
    if ((ua % 4) != 0) begin
      e.d = 32'h0; e.r = 2'b10;
    end else if (ua < longint'(BASE) || ua >= longint'(BASE) + 4 * DEPTH) begin
      e.d = 32'h0; e.r = 2'b11;
    end else begin
      e.d = mem_m[int'((ua - longint'(BASE)) / 4)]; e.r = 2'b00;
    end
  endtask

  // Monitor: samples on the falling edge, compares against the queue head.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    cyc++;
    if (!reset) begin
      seen_rv   = 0;
      after_pop = 0;
    end else begin
      if (after_pop) begin
        chk("arready_after_r", 64'(arready), 64'd1);
        after_pop = 0;
      end
      if (arvalid && arready) hs_cyc = cyc;
      if (rvalid) begin
        chk("arready_in_resp", 64'(arready), 64'd0);
        if (!seen_rv) begin
          seen_rv = 1;
          lat = cyc - hs_cyc;
`ifdef IMEM_RAND_DELAY_EN
          total++;
          if (lat >= LAT + 1 && lat <= LAT + 4) passed++;
          else $display("FAIL latency: got %0d, want %0d..%0d", lat, LAT + 1, LAT + 4);
`else
          chk("latency", 64'(lat), 64'(LAT + 1));
`endif
        end
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_resp: got rdata=%0h rresp=%0h, want no response", rdata, rresp);
        end else begin
          e = exp_q[0];
          chk("rdata", 64'(rdata), 64'(e.d));
          chk("rresp", 64'(rresp), 64'(e.r));
          if (rready) begin
            void'(exp_q.pop_front());
            seen_rv   = 0;
            after_pop = 1;
          end
        end
      end
    end
  end

  // Driver phase: all input changes happen 1ns after a rising edge.
  task automatic fetch(input logic [31:0] a, input int stall);
    exp_t e;
    bit   ok;
    model(a, e);
    exp_q.push_back(e);
    rready  = (stall == 0);
    araddr  = a;
    arvalid = 1'b1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    chk("ar_accepted", 64'(ok), 64'd1);
    if (!ok) begin
      arvalid = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    araddr  = $urandom;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; break; end
    end
    chk("r_arrived", 64'(ok), 64'd1);
    if (!ok) begin
      exp_q.delete();
      rready = 1'b1;
      @(posedge clk); #1;
      return;
    end
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      @(posedge clk); #1;
      rready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic init_word(input int idx, input logic [31:0] d);
    init_we   = 1'b1;
    init_idx  = IDX_W'(idx);
    init_data = d;
    mem_m[idx] = d;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    chk("arready_before_first_edge", 64'(arready), 64'd0);
    @(negedge clk);
    chk("arready_after_release", 64'(arready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    int          stall;
    bit          ok;

    reset = 1'b0; arvalid = 1'b0; araddr = '0; rready = 1'b0;
    init_we = 1'b0; init_idx = '0; init_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_rdata",   64'(rdata),   64'd0);
    chk("rst_rresp",   64'(rresp),   64'd0);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("arready_no_edge_yet", 64'(arready), 64'd0);
    @(negedge clk);
    chk("arready_idle", 64'(arready), 64'd1);
    @(posedge clk); #1;

    init_we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      init_idx  = IDX_W'(i);
      init_data = (i == 0) ? 32'h0000_0413 : $urandom;
      mem_m[i]  = init_data;
      @(posedge clk); #1;
    end
    init_we = 1'b0;

    fetch(BASE, 0);
    fetch(BASE + 32'd2, 0);
    fetch(32'h3000_0000, 0);
    fetch(BASE + 32'd1, 0);
    fetch(BASE + 32'd3, 0);
    fetch(BASE + 32'(4 * DEPTH) - 32'd4, 0);
    fetch(BASE + 32'(4 * DEPTH), 0);
    fetch(32'hFFFF_FFFC, 0);
    fetch(BASE - 32'd4, 0);
    fetch(BASE + 32'd8, 5);

    // Reset while waiting: transaction dropped, no response afterwards.
    rready  = 1'b1;
    araddr  = BASE + 32'd16;
    arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("wait_arready", 64'(arready), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_wait_rvalid",  64'(rvalid),  64'd0);
    chk("rst_wait_arready", 64'(arready), 64'd0);
    release_reset();
    fetch(BASE, 0);

    // Reset while a response is pending: rvalid drops without a clock.
    begin
      exp_t e;
      model(BASE + 32'd4, e);
      exp_q.push_back(e);
    end
    rready  = 1'b0;
    araddr  = BASE + 32'd4;
    arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    arvalid = 1'b0;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; break; end
    end
    chk("resp_before_reset", 64'(ok), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_resp_rvalid", 64'(rvalid), 64'd0);
    chk("rst_resp_rdata",  64'(rdata),  64'd0);
    chk("rst_resp_rresp",  64'(rresp),  64'd0);
    exp_q.delete();
    rready = 1'b1;
    release_reset();
    fetch(BASE, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom % 4 == 0) init_word(int'($urandom % DEPTH), $urandom);
      kind = int'($urandom % 8);
      case (kind)
        0: a = BASE + 32'(($urandom % DEPTH) * 4) + 32'($urandom_range(1, 3));
        1: a = $urandom % BASE;
        2: a = BASE + 32'(4 * DEPTH) + ($urandom % 32'h7FFF_0000);
        3: a = BASE + 32'(4 * DEPTH) - 32'd4;
        4: a = BASE + 32'(4 * DEPTH);
        default: a = BASE + 32'(($urandom % DEPTH) * 4);
      endcase
      stall = ($urandom % 3 == 0) ? int'($urandom_range(1, 4)) : 0;
      repeat ($urandom % 3) begin @(posedge clk); #1; end
      fetch(a, stall);
    end

    for (int n = 0; n < 16; n++) begin
      fetch(BASE + 32'(($urandom % DEPTH) * 4), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
